// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, FSM encoding and access-legality helper for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Memory geometry shared with datamemory.
    localparam int MEM_SIZE         = 256;
    localparam int INSTRUCTION_SIZE = 32;

    // RV32I load/store funct3 encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Sequencer states: IDLE picks a requester, ACCESS drives memory for one cycle.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Returns 1 when funct3 is valid for the direction and the address is naturally aligned.
    function automatic logic access_legal(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: the master that did not own the last access wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

    // Single requester wins outright; a tie goes to the master that was not served last.
    always_comb begin
        any    = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of the single-port data memory.
// One access per two cycles: IDLE samples and latches the winning request, ACCESS drives
// memory for one cycle and the result is returned as an rvalid pulse in the following IDLE cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = $clog2(MEM_SIZE),
    parameter int DATA_W = INSTRUCTION_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_funct3,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_funct3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Per-master request fields gathered into arrays so the winner can index them.
    logic [1:0]        req_vec;
    logic              we_vec     [2];
    logic [ADDR_W-1:0] addr_vec   [2];
    logic [DATA_W-1:0] wdata_vec  [2];
    logic [2:0]        funct3_vec [2];

    assign req_vec       = {m1_req, m0_req};
    assign we_vec[0]     = m0_we;
    assign we_vec[1]     = m1_we;
    assign addr_vec[0]   = m0_addr;
    assign addr_vec[1]   = m1_addr;
    assign wdata_vec[0]  = m0_wdata;
    assign wdata_vec[1]  = m1_wdata;
    assign funct3_vec[0] = m0_funct3;
    assign funct3_vec[1] = m1_funct3;

    state_t            state_reg, state_next;
    logic              last_owner_reg;
    logic              owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [2:0]        funct3_reg;
    logic              legal_reg;

    logic              rvalid_reg [2];
    logic              err_reg    [2];
    logic [DATA_W-1:0] rdata_reg  [2];
    logic [1:0]        gnt_vec;

    logic              winner;
    logic              any_req;
    logic              sel_legal;

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_owner (last_owner_reg),
        .winner     (winner),
        .any        (any_req)
    );

    assign sel_legal = access_legal(we_vec[winner], funct3_vec[winner], addr_vec[winner][1:0]);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, grant and memory-side drive; memory strobes are gated by reset so a
    // reset edge can never land a write.
    always_comb begin
        state_next     = state_reg;
        gnt_vec        = 2'b00;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_funct3     = 3'b000;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next         = ST_IDLE;
                gnt_vec[owner_reg] = 1'b1;
                mem_address        = addr_reg;
                mem_write_data     = wdata_reg;
                mem_funct3         = funct3_reg;
                mem_read           = legal_reg & ~we_reg & reset;
                mem_write          = legal_reg & we_reg & reset;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch the winning request in IDLE and record who was served when ACCESS ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_owner_reg <= 1'b1;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            funct3_reg     <= 3'b000;
            legal_reg      <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && any_req) begin
                owner_reg  <= winner;
                we_reg     <= we_vec[winner];
                addr_reg   <= addr_vec[winner];
                wdata_reg  <= wdata_vec[winner];
                funct3_reg <= funct3_vec[winner];
                legal_reg  <= sel_legal;
            end
            if (state_reg == ST_ACCESS) begin
                last_owner_reg <= owner_reg;
            end
        end
    end

    // Per-master response registers: the owner gets a one-cycle rvalid/err pulse and its
    // load data; the other master's rdata holds.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else if (state_reg == ST_ACCESS && owner_reg == 1'(gi)) begin
                    rvalid_reg[gi] <= 1'b1;
                    err_reg[gi]    <= ~legal_reg;
                    rdata_reg[gi]  <= (legal_reg && !we_reg) ? mem_read_data : '0;
                end else begin
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                end
            end
        end
    endgenerate

    assign m0_gnt    = gnt_vec[0];
    assign m1_gnt    = gnt_vec[1];
    assign m0_rvalid = rvalid_reg[0];
    assign m1_rvalid = rvalid_reg[1];
    assign m0_err    = err_reg[0];
    assign m1_err    = err_reg[1];
    assign m0_rdata  = rdata_reg[0];
    assign m1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural datamemory and an rvalid scoreboard.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [2:0]        m0_funct3, m1_funct3;
    logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic [2:0]        mem_funct3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
    );

    // Behavioural byte-addressed little-endian datamemory.
    logic [7:0] mem_bytes [256];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_address;
    assign a1 = mem_address + 8'd1;
    assign a2 = mem_address + 8'd2;
    assign a3 = mem_address + 8'd3;

    always_comb begin
        mem_read_data = '0;
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{mem_bytes[a0][7]}}, mem_bytes[a0]};
            3'b001:  mem_read_data = {{16{mem_bytes[a1][7]}}, mem_bytes[a1], mem_bytes[a0]};
            3'b010:  mem_read_data = {mem_bytes[a3], mem_bytes[a2], mem_bytes[a1], mem_bytes[a0]};
            3'b100:  mem_read_data = {24'd0, mem_bytes[a0]};
            3'b101:  mem_read_data = {16'd0, mem_bytes[a1], mem_bytes[a0]};
            default: mem_read_data = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_funct3)
                3'b000: mem_bytes[a0] <= mem_write_data[7:0];
                3'b001: begin
                    mem_bytes[a0] <= mem_write_data[7:0];
                    mem_bytes[a1] <= mem_write_data[15:8];
                end
                3'b010: begin
                    mem_bytes[a0] <= mem_write_data[7:0];
                    mem_bytes[a1] <= mem_write_data[15:8];
                    mem_bytes[a2] <= mem_write_data[23:16];
                    mem_bytes[a3] <= mem_write_data[31:24];
                end
                default: ;
            endcase
        end
    end

    // Scoreboard of expected responses per master.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Pop and compare whenever a master reports completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (m0_rvalid === 1'b1) begin
            if (exp_q0.size() == 0) begin
                check("m0_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q0.pop_front();
                check("m0_rdata", m0_rdata, e.rdata);
                check("m0_err", {31'd0, m0_err}, {31'd0, e.err});
            end
        end
        if (m1_rvalid === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("m1_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("m1_rdata", m1_rdata, e.rdata);
                check("m1_err", {31'd0, m1_err}, {31'd0, e.err});
            end
        end
    end

    function automatic logic gnt_of(input int m);
        return (m == 1) ? m1_gnt : m0_gnt;
    endfunction

    function automatic logic rvalid_of(input int m);
        return (m == 1) ? m1_rvalid : m0_rvalid;
    endfunction

    task automatic set_req(input int m, input logic rq, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
        if (m == 1) begin
            m1_req = rq; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_funct3 = f3;
        end else begin
            m0_req = rq; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_funct3 = f3;
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        if (m == 1) exp_q1.push_back(e);
        else        exp_q0.push_back(e);
    endtask

    // One uncontended access: gnt expected in the cycle after the request, rvalid one cycle later.
    task automatic single(input int m, input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                          input string tag);
        push_exp(m, exp_rdata, exp_err);
        @(posedge clk); #1;
        set_req(m, 1'b1, we, addr, wdata, f3);
        @(negedge clk);
        check({tag, "_gnt_c1"}, {31'd0, gnt_of(m)}, 32'd0);
        @(negedge clk);
        check({tag, "_gnt_c2"}, {31'd0, gnt_of(m)}, 32'd1);
        check({tag, "_mem_read"}, {31'd0, mem_read}, {31'd0, (!exp_err && !we)});
        check({tag, "_mem_write"}, {31'd0, mem_write}, {31'd0, (!exp_err && we)});
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        @(negedge clk);
        check({tag, "_rvalid"}, {31'd0, rvalid_of(m)}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int   ng;
        logic prev_g, cur_g;
        int   order [4];

        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_mem_ctl", {27'd0, mem_read, mem_write, mem_funct3}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_address}, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);

        // Store then load a word from master 0.
        single(0, 1'b1, 8'h00, 32'hAABBCCDD, 3'b010, 32'h0, 1'b0, "t1_sw");
        single(0, 1'b0, 8'h00, 32'h0, 3'b010, 32'hAABBCCDD, 1'b0, "t1_lw");

        // Simultaneous requests after reset: master 0 wins first tie.
        do_reset();
        push_exp(0, 32'hAABBCCDD, 1'b0);
        push_exp(1, 32'h0, 1'b0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        set_req(1, 1'b1, 1'b1, 8'h10, 32'h0000BEEF, 3'b001);
        @(negedge clk);
        check("t2_c1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        @(negedge clk);
        check("t2_c2_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        @(negedge clk);
        check("t2_c3_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        @(negedge clk);
        check("t2_c4_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        @(negedge clk);
        single(1, 1'b0, 8'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, "t2_lh");
        single(1, 1'b0, 8'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0, "t2_lhu");
        check("t2_m0_rdata_hold", m0_rdata, 32'hAABBCCDD);

        // Both masters hold requests: grants must alternate, never back to back.
        do_reset();
        repeat (2) push_exp(0, 32'hAABBCCDD, 1'b0);
        repeat (2) push_exp(1, 32'hAABBCCDD, 1'b0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        set_req(1, 1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        ng = 0;
        prev_g = 1'b0;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            @(negedge clk);
            cur_g = m0_gnt | m1_gnt;
            check("t3_no_b2b", {31'd0, prev_g & cur_g}, 32'd0);
            check("t3_one_hot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
            if (cur_g) begin
                order[ng] = m1_gnt ? 1 : 0;
                ng++;
                if (ng == 3) begin
                    @(posedge clk); #1;
                    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
                end
            end
            prev_g = cur_g;
        end
        check("t3_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("t3_order%0d", i), order[i], i % 2);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        repeat (2) @(negedge clk);

        // Illegal accesses never reach memory.
        single(1, 1'b0, 8'h02, 32'h0, 3'b010, 32'h0, 1'b1, "t4_lw_mis");
        single(1, 1'b1, 8'h00, 32'h00000055, 3'b100, 32'h0, 1'b1, "t4_sb_bad");
        single(0, 1'b0, 8'h00, 32'h0, 3'b010, 32'hAABBCCDD, 1'b0, "t4_lw_chk");

        // Byte store and signed/unsigned byte loads.
        single(0, 1'b1, 8'h20, 32'h000000AA, 3'b000, 32'h0, 1'b0, "t5_sb");
        single(0, 1'b0, 8'h20, 32'h0, 3'b000, 32'hFFFFFFAA, 1'b0, "t5_lb");
        single(0, 1'b0, 8'h20, 32'h0, 3'b100, 32'h000000AA, 1'b0, "t5_lbu");

        // Reset during ACCESS aborts the store.
        single(0, 1'b1, 8'h30, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "t6_pre_sw");
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 8'h30, 32'h12345678, 3'b010);
        @(negedge clk);
        @(negedge clk);
        check("t6_gnt", {31'd0, m0_gnt}, 32'd1);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        #1;
        check("t6_write_gated", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        check("t6_post_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("t6_post_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("t6_post_err", {30'd0, m1_err, m0_err}, 32'd0);
        check("t6_post_rdata", m0_rdata | m1_rdata, 32'd0);
        check("t6_post_mem", {27'd0, mem_read, mem_write, mem_funct3}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        single(0, 1'b0, 8'h30, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "t6_lw");

        repeat (2) @(negedge clk);
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
